// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: byte-level command decoder behind an SPI slave.
// Opcodes: 0x01 write burst, 0x02 read burst, 0x03 ping, others flag an error.
// The register file is 2**ADDR_W bytes. Register 0 is mirrored on ctrl_out one clk later.
// Optional feature: define SPI_CMD_ERRCNT_EN to build the saturating protocol-error counter.
// Without it, err_count is tied to 0x00.
module spi_cmd_decoder #(
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic [7:0] ctrl_out,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, CMD, WADDR, WDATA, RADDR, RDATA, PING, ERR
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next, ptr_inc, rx_addr;
  logic [7:0]        regs [NREG];
  logic [7:0]        tx_next;
  logic              wr_en;
  logic              addr_ok;

  // An address byte is legal only when it indexes an existing register.
  assign addr_ok = ({1'b0, rx_byte} < 9'(NREG));
  assign rx_addr = rx_byte[ADDR_W-1:0];
  assign ptr_inc = ptr + ADDR_W'(1);
  assign busy    = (state != IDLE);

  // Next-state, pointer, write strobe and next response byte.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    tx_next    = tx_byte;
    wr_en      = 1'b0;
    if (state == IDLE) begin
      // Bytes seen before the frame has been registered as started are dropped.
      if (frame_active) state_next = CMD;
    end else if (!frame_active) begin
      // The end of the frame wins over a byte arriving in the same clk.
      state_next = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        CMD: begin
          unique case (rx_byte)
            8'h01:   state_next = WADDR;
            8'h02:   state_next = RADDR;
            8'h03:   state_next = PING;
            default: state_next = ERR;
          endcase
        end
        WADDR: begin
          if (addr_ok) begin
            ptr_next   = rx_addr;
            state_next = WDATA;
          end else begin
            state_next = ERR;
          end
        end
        RADDR: begin
          if (addr_ok) begin
            ptr_next   = rx_addr;
            state_next = RDATA;
            tx_next    = regs[rx_addr];
          end else begin
            state_next = ERR;
          end
        end
        WDATA: begin
          wr_en    = 1'b1;
          ptr_next = ptr_inc;
        end
        RDATA: begin
          // The byte just shifted out was regs[ptr]; stage the following one.
          ptr_next = ptr_inc;
          tx_next  = regs[ptr_inc];
        end
        default: ;
      endcase
    end
    // Outside RDATA the response byte is a fixed code of the state being entered.
    unique case (state_next)
      PING:    tx_next = 8'h05;
      ERR:     tx_next = 8'hEE;
      RDATA:   ;
      default: tx_next = 8'h00;
    endcase
  end

  // State, pointer and response byte registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      tx_byte <= 8'h00;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      tx_byte <= tx_next;
    end
  end

  // Register file; cleared by reset, so it is built from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[ptr] <= rx_byte;
    end
  end

  // Mirror of register 0, following it by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_out <= 8'h00;
    else        ctrl_out <= regs[0];
  end

`ifdef SPI_CMD_ERRCNT_EN
  logic       err_entry;
  logic [7:0] err_cnt;

  assign err_entry = (state_next == ERR) && (state != ERR);
  assign err_count = err_cnt;

  // Count entries into ERR, holding at 0xFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_cnt <= 8'h00;
    else if (err_entry && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'h01;
  end
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Testbench for spi_cmd_decoder (ADDR_W=3). A frame-level model (byte queue per
// frame, plain register array) predicts tx_byte/ctrl_out/err_count/busy every clk.
module tb_spi_cmd_decoder;

  localparam int ADDR_W = 3;
  localparam int NREG   = 8;
`ifdef SPI_CMD_ERRCNT_EN
  localparam logic [7:0] ERR2   = 8'd2;
  localparam logic [7:0] ERRSAT = 8'hFF;
`else
  localparam logic [7:0] ERR2   = 8'd0;
  localparam logic [7:0] ERRSAT = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_active = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte, ctrl_out, err_count;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  spi_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(tx_byte), .ctrl_out(ctrl_out),
    .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%02h expected=%02h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [7:0]  m_mem [NREG];
  byte unsigned m_q[$];
  bit          m_in  = 1'b0;
  bit          m_err = 1'b0;
  int          m_errs = 0;
  logic [7:0]  m_tx = 8'h00;
  logic [7:0]  m_ctrl = 8'h00;

  function automatic logic [7:0] model_tx();
    int n = m_q.size();
    if (!m_in || n == 0) return 8'h00;
    if (m_err)           return 8'hEE;
    if (m_q[0] == 3)     return 8'h05;
    if (m_q[0] == 2 && n >= 2) return m_mem[(m_q[1] + n - 2) % NREG];
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) m_mem[i] = 8'h00;
      m_q.delete();
      m_in = 0; m_err = 0; m_errs = 0; m_tx = 8'h00; m_ctrl = 8'h00;
    end else begin
      m_ctrl = m_mem[0];
      if (!m_in) begin
        if (frame_active) begin
          m_in = 1; m_err = 0; m_q.delete();
        end
      end else if (!frame_active) begin
        m_in = 0; m_q.delete();
      end else if (rx_valid && !m_err) begin
        int n;
        m_q.push_back(rx_byte);
        n = m_q.size();
        if (n == 1 && !(rx_byte inside {8'h01, 8'h02, 8'h03})) m_err = 1;
        else if (n == 2 && (m_q[0] == 1 || m_q[0] == 2) && rx_byte >= NREG) m_err = 1;
        else if (n >= 3 && m_q[0] == 1) m_mem[(m_q[1] + n - 3) % NREG] = rx_byte;
        if (m_err) m_errs++;
      end
      m_tx = model_tx();
    end
  end

  function automatic logic [7:0] model_errcnt();
`ifdef SPI_CMD_ERRCNT_EN
    return (m_errs > 255) ? 8'hFF : 8'(m_errs);
`else
    return 8'h00;
`endif
  endfunction

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("tx_byte",   tx_byte,   m_tx);
      check("ctrl_out",  ctrl_out,  m_ctrl);
      check("err_count", err_count, model_errcnt());
      check("busy",      {7'd0, busy}, {7'd0, m_in});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    step();
    rx_valid = 1'b0; rx_byte = 8'($urandom);
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic start_frame();
    frame_active = 1'b1;
    step();
  endtask

  task automatic end_frame();
    frame_active = 1'b0;
    step();
    step();
  endtask

  task automatic frame(input byte unsigned bytes[$]);
    start_frame();
    foreach (bytes[i]) send_byte(bytes[i]);
    end_frame();
    $display("frame len=%0d op=%02h tx=%02h ctrl=%02h errs=%02h", bytes.size(),
             (bytes.size() > 0) ? bytes[0] : 8'h00, tx_byte, ctrl_out, err_count);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_tx", tx_byte, 8'h00);
    check("rst_ctrl", ctrl_out, 8'h00);
    check("rst_err", err_count, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    repeat (3) step();
    rst_n = 1'b1;
    chk_on = 1'b1;
    step();

    // Write 0xA5 to reg2, read it back
    frame('{8'h01, 8'h02, 8'hA5});
    start_frame();
    send_byte(8'h02);
    send_byte(8'h02);
    check("rd_reg2", tx_byte, 8'hA5);
    send_byte(8'h3C);
    end_frame();
    $display("read reg2 done");

    // Write burst wrapping 7 -> 0
    frame('{8'h01, 8'h07, 8'h11, 8'h22});
    check("wrap_ctrl", ctrl_out, 8'h22);
    start_frame();
    send_byte(8'h02);
    send_byte(8'h07);
    check("wrap_rd7", tx_byte, 8'h11);
    send_byte(8'h00);
    check("wrap_rd0", tx_byte, 8'h22);
    end_frame();
    $display("wrap read done");

    // Ping
    start_frame();
    send_byte(8'h03);
    check("ping_op", tx_byte, 8'h05);
    send_byte(8'h9A);
    send_byte(8'h9B);
    check("ping_hold", tx_byte, 8'h05);
    end_frame();
    check("ping_end", tx_byte, 8'h00);
    $display("ping done");

    // Errors: bad opcode, then out-of-range address
    start_frame();
    send_byte(8'h7F);
    check("err_op", tx_byte, 8'hEE);
    send_byte(8'h01);
    check("err_ignore", tx_byte, 8'hEE);
    end_frame();
    start_frame();
    send_byte(8'h01);
    send_byte(8'h08);
    check("err_addr", tx_byte, 8'hEE);
    end_frame();
    check("err_cnt2", err_count, ERR2);
    $display("errors done");

    // Abort: frame ends in the same clk as a WDATA byte
    start_frame();
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h5A);
    frame_active = 1'b0; rx_valid = 1'b1; rx_byte = 8'h99;
    step();
    rx_valid = 1'b0;
    check("abort_busy", {7'd0, busy}, 8'h00);
    step();
    start_frame();
    send_byte(8'h02);
    send_byte(8'h04);
    check("abort_nowr", tx_byte, 8'h00);
    end_frame();
    $display("abort done");

    // Reset pulsed mid-WDATA
    start_frame();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h77);
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_tx", tx_byte, 8'h00);
    check("mrst_ctrl", ctrl_out, 8'h00);
    check("mrst_err", err_count, 8'h00);
    check("mrst_busy", {7'd0, busy}, 8'h00);
    frame_active = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    start_frame();
    send_byte(8'h02);
    send_byte(8'h00);
    check("mrst_reg0", tx_byte, 8'h00);
    send_byte(8'h00);
    check("mrst_reg1", tx_byte, 8'h00);
    end_frame();
    $display("mid-frame reset done");

    // Randomized frames
    for (int f = 0; f < 200; f++) begin
      byte unsigned q[$];
      int sel = $urandom_range(0, 9);
      int len = $urandom_range(0, 5);
      if (sel < 4)      q.push_back(8'h01);
      else if (sel < 7) q.push_back(8'h02);
      else if (sel < 8) q.push_back(8'h03);
      else              q.push_back(8'($urandom));
      q.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)));
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        // Stray byte outside a frame and one coinciding with frame start
        rx_valid = 1'b1; rx_byte = 8'h01;
        step();
        frame_active = 1'b1; rx_byte = 8'h02;
        step();
        rx_valid = 1'b0;
        foreach (q[i]) send_byte(q[i]);
        if ($urandom_range(0, 1) == 0) begin
          frame_active = 1'b0; rx_valid = 1'b1; rx_byte = 8'($urandom);
          step();
          rx_valid = 1'b0;
          step();
        end else begin
          end_frame();
        end
        $display("frame rand-edge len=%0d op=%02h", q.size(), q[0]);
      end else begin
        frame(q);
      end
    end

    // Drive the error counter to saturation
    for (int f = 0; f < 260; f++) begin
      start_frame();
      rx_valid = 1'b1; rx_byte = 8'hFF;
      step();
      rx_valid = 1'b0;
      frame_active = 1'b0;
      step();
    end
    step();
    check("err_sat", err_count, ERRSAT);
    $display("saturation done errs=%02h", err_count);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have parameter: ADDR_W, default 3, register-file address width (legal 1..7; 2**ADDR_W registers of 8 bits).
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: frame_active  in  1  high while the SPI slave-select is active.
REQ-005 SHALL have ports: rx_valid  in  1  one-clk pulse when a received byte is available.
REQ-006 SHALL have ports: rx_byte  in  8  received byte, valid when rx_valid=1.
REQ-007 SHALL have ports: tx_byte  out  8  response byte handed to the SPI slave for the next transfer.
REQ-008 SHALL have ports: ctrl_out  out  8  continuous copy of register 0.
REQ-009 SHALL have ports: err_count  out  8  number of protocol errors.
REQ-010 SHALL have ports: busy  out  1  high when state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, CMD, WADDR, WDATA, RADDR, RDATA, PING, ERR.
REQ-012 SHALL go from IDLE to CMD on the first clk with frame_active=1; rx_valid in IDLE SHALL be ignored.
REQ-013 SHALL go to IDLE on the clk after frame_active=0, from any state; this terminates the frame, and register writes already done SHALL persist.
REQ-014 SHALL decode the first byte in CMD: 0x01 -> WADDR, 0x02 -> RADDR, 0x03 -> PING, any other value -> ERR.
REQ-015 SHALL check addresses in WADDR/RADDR: if rx_byte >= 2**ADDR_W -> ERR; else latch the pointer and go to WDATA or RDATA.
REQ-016 SHALL, in WDATA, write each rx_byte to reg[pointer] and then increment the pointer, wrapping (2**ADDR_W)-1 -> 0.
REQ-017 SHALL, in RDATA, load tx_byte=reg[pointer] at the clk after entry and after each rx_valid, incrementing the pointer after each rx_valid with wrap.
REQ-018 SHALL drive tx_byte=0x05 while in PING, 0xEE while in ERR, and 0x00 in IDLE, CMD, WADDR and WDATA.
REQ-019 SHALL keep all state transitions and tx_byte updates registered, with one clk of latency after rx_valid or state entry.
REQ-020 SHALL ignore rx_valid in ERR until the frame ends.
REQ-021 SHALL increment err_count by 1 on each entry to ERR, saturating at 0xFF.
REQ-022 SHALL give frame_active=0 priority when it coincides with rx_valid: the byte is discarded and no write is performed.
REQ-023 SHALL update ctrl_out on the clk after register 0 is written.

Reset
REQ-024 SHALL, on rst_n=0 (asynchronous, regardless of clk), set state=IDLE, pointer=0, all registers=0x00, tx_byte=0x00, ctrl_out=0x00, err_count=0x00, busy=0.
REQ-025 SHALL, on reset asserted mid-frame, abandon the frame; after release it SHALL wait in IDLE until frame_active is next seen high.

Configuration
REQ-026 SHALL, with macro SPI_CMD_ERRCNT_EN defined, implement err_count per REQ-021.
REQ-027 SHALL, without SPI_CMD_ERRCNT_EN, tie err_count to constant 0x00 and synthesize no counter; all other behaviour SHALL be unchanged.

Verification
REQ-028 SHALL cover write/read: frame {0x01,0x02,0xA5}, then frame {0x02,0x02,xx} -> reg2=0xA5; tx_byte=0xA5 one clk after the address byte.
REQ-029 SHALL cover wrap (ADDR_W=3): frame {0x01,0x07,0x11,0x22} -> reg7=0x11, reg0=0x22, ctrl_out=0x22.
REQ-030 SHALL cover ping: frame {0x03,xx,xx} -> tx_byte=0x05 from the clk after the opcode until the frame ends, then 0x00.
REQ-031 SHALL cover errors: opcode 0x7F, then frame {0x01,0x08} -> tx_byte=0xEE in both frames, err_count=2 (0 without SPI_CMD_ERRCNT_EN), no register changed.
REQ-032 SHALL cover frame abort and reset: frame_active falls in the same clk as rx_valid of a WDATA byte -> no write, state=IDLE; rst_n pulsed mid-WDATA -> all registers 0x00, busy=0.
